// File: rtl/light_package.sv
// light_package: light colours, controller states and shared timing helpers.
package light_package;
  typedef enum logic [1:0] {C_RED = 2'd0, C_YELLOW = 2'd1, C_GREEN = 2'd2} colors;
  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} tlc_state_t;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/tlc_rr_arbiter.sv
// tlc_rr_arbiter: picks the first requesting phase above ptr, wrapping modulo NUM_PHASES.
module tlc_rr_arbiter #(
  parameter int NUM_PHASES = 5
) (
  input  logic [NUM_PHASES-1:0]         req,
  input  logic [$clog2(NUM_PHASES)-1:0] ptr,
  output logic [$clog2(NUM_PHASES)-1:0] gnt,
  output logic                          vld
);
  localparam int PW = $clog2(NUM_PHASES);
  logic [PW-1:0] idx;
  // Scanning from the farthest candidate down leaves the nearest requester in gnt.
  always_comb begin
    gnt = ptr;
    idx = '0;
    vld = |req;
    for (int i = NUM_PHASES; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_PHASES);
      if (req[idx]) gnt = idx;
    end
  end
endmodule

// File: rtl/multi_phase_tlc.sv
// multi_phase_tlc: N-phase traffic controller with gap/max green timing and preemption.
module multi_phase_tlc
  import light_package::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int GAP_CYC    = 5,
  parameter int MAX_CYC    = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PHASES-1:0]              phase_req,
  input  logic                               preempt_req,
  input  logic [$clog2(NUM_PHASES)-1:0]      preempt_phase,
  output logic [NUM_PHASES-1:0][1:0]         phase_light,
  output logic [$clog2(NUM_PHASES)-1:0]      active_phase,
  output logic                               in_green
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam int CW = $clog2(max4(YELLOW_CYC, ALLRED_CYC, GAP_CYC, MAX_CYC)) + 1;
  tlc_state_t state;
  logic [PW-1:0] ptr, gnt;
  logic [CW-1:0] tmr, gap, mx;
  logic gnt_vld, pre_ok, own, others, run, gap_hit, max_hit, ready;
  tlc_rr_arbiter #(.NUM_PHASES(NUM_PHASES)) u_arb (
    .req(phase_req),
    .ptr(ptr),
    .gnt(gnt),
    .vld(gnt_vld)
  );
  assign pre_ok  = preempt_req && int'(preempt_phase) < NUM_PHASES;
  assign own     = phase_req[ptr];
  assign others  = |(phase_req & ~(NUM_PHASES'(1) << ptr));
  // The max counter is nonzero once started, so it doubles as its own run flag.
  assign run     = mx != '0 || others;
  assign gap_hit = !own && gap + CW'(1) == CW'(GAP_CYC);
  assign max_hit = run && mx + CW'(1) == CW'(MAX_CYC);
  assign ready   = tmr + CW'(1) >= CW'(ALLRED_CYC);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ALLRED;
      ptr   <= PW'(NUM_PHASES - 1);
      tmr   <= '0;
      gap   <= '0;
      mx    <= '0;
    end else begin
      case (state)
        ALLRED: begin
          if (ready && (pre_ok || gnt_vld)) begin
            state <= GREEN;
            ptr   <= pre_ok ? preempt_phase : gnt;
            tmr   <= '0;
            gap   <= '0;
            mx    <= '0;
          end else if (!ready) tmr <= tmr + CW'(1);
        end
        GREEN: begin
          if (pre_ok && preempt_phase != ptr) begin
            state <= YELLOW;
            tmr   <= '0;
          end else if (!pre_ok) begin
            gap <= own ? '0 : gap + CW'(1);
            mx  <= run ? mx + CW'(1) : mx;
            if (gap_hit || max_hit) begin
              state <= YELLOW;
              tmr   <= '0;
            end
          end
        end
        YELLOW: begin
          state <= tmr + CW'(1) == CW'(YELLOW_CYC) ? ALLRED : YELLOW;
          tmr   <= tmr + CW'(1) == CW'(YELLOW_CYC) ? '0 : tmr + CW'(1);
        end
        default: state <= ALLRED;
      endcase
    end
  end
  always_comb begin
    for (int p = 0; p < NUM_PHASES; p++)
      phase_light[p] = (state != ALLRED && ptr == PW'(p)) ? (state == GREEN ? C_GREEN : C_YELLOW) : C_RED;
  end
  assign active_phase = ptr;
  assign in_green     = state == GREEN;
endmodule

// File: doc/multi_phase_tlc.md
MULTI_PHASE_TLC -- requirements
Module: multi_phase_tlc

Interface
REQ-001 Parameter NUM_PHASES, default 5: number of mutually conflicting signal phases, legal range 2..8.
REQ-002 Parameter YELLOW_CYC, default 2: yellow duration in cycles, at least 1.
REQ-003 Parameter ALLRED_CYC, default 1: minimum all-red clearance in cycles, at least 1.
REQ-004 Parameter GAP_CYC, default 5: green extension after own demand drops, at least 1.
REQ-005 Parameter MAX_CYC, default 10: green limit once conflicting demand exists, at least 1.
REQ-006 Ports SHALL be:
  clk  input  1  clock, rising edge.
  reset  input  1  reset, synchronous, active-high.
  phase_req  input  NUM_PHASES  per-phase demand, bit p is phase p.
  preempt_req  input  1  emergency preemption request.
  preempt_phase  input  $clog2(NUM_PHASES)  phase to be served by preemption.
  phase_light  output  NUM_PHASES x colors  per-phase light (red/yellow/green).
  active_phase  output  $clog2(NUM_PHASES)  phase currently green or yellow, else the last served phase.
  in_green  output  1  high only while in GREEN.

Function
REQ-007 The FSM SHALL have exactly three states: ALLRED, GREEN and YELLOW.
REQ-008 At most one phase SHALL be non-red in any cycle, and every other phase SHALL be red.
REQ-009 Outputs SHALL be Moore-decoded from registered state:
  - GREEN: phase_light[active_phase]=green.
  - YELLOW: phase_light[active_phase]=yellow.
  - ALLRED: all phases red.
REQ-010 ALLRED SHALL last at least ALLRED_CYC cycles, and SHALL then grant on that last cycle so that GREEN starts on the following cycle.
REQ-011 Grant priority in ALLRED SHALL be:
  - A valid preempt_req (preempt_phase < NUM_PHASES) grants preempt_phase.
  - Otherwise, round-robin grants the first requesting phase after the pointer, searching upward modulo NUM_PHASES.
  - With no requests, the FSM stays in ALLRED (idle) and re-evaluates every cycle.
REQ-012 The round-robin pointer SHALL load the granted phase on each grant.
REQ-013 Gap counter:
  - Increments each GREEN cycle in which phase_req[active_phase]=0.
  - Clears when phase_req[active_phase]=1.
  - Exit to YELLOW when its incremented value equals GAP_CYC.
REQ-014 Max counter:
  - Starts on the first GREEN cycle in which any other phase_req bit is 1, then increments every GREEN cycle even if that demand drops.
  - Exit to YELLOW when its incremented value equals MAX_CYC.
REQ-015 If both the gap and max exits occur in the same cycle, the FSM SHALL take one transition to YELLOW.
REQ-016 With only its own demand present, GREEN SHALL rest indefinitely.
REQ-017 YELLOW SHALL last exactly YELLOW_CYC cycles, then enter ALLRED.
REQ-018 YELLOW and ALLRED SHALL never be truncated by any input.
REQ-019 Preemption in GREEN:
  - For a different valid phase, GREEN moves to YELLOW on the next cycle.
  - For the same phase, GREEN holds with both counters frozen while preempt_req=1.
REQ-020 An invalid preempt_phase SHALL be ignored.
REQ-021 Both counters SHALL clear on every entry to GREEN.
REQ-022 Counter widths SHALL be $clog2 of the largest timing parameter plus 1, so that no wrap-around occurs.

Reset
REQ-023 Reset SHALL put the block in this state, with active_phase=NUM_PHASES-1:
  - state ALLRED with its clearance timer restarted, all lights red, in_green=0;
  - round-robin pointer=NUM_PHASES-1, all counters 0.
REQ-024 Reset asserted mid-GREEN or mid-YELLOW SHALL force all lights red on the next cycle, with no yellow.

Structure
REQ-025 The colors enum and a new tlc_state_t enum SHALL reside in light_package.
REQ-026 The round-robin phase selection SHALL be a combinational sub-module, tlc_rr_arbiter, parametrised by NUM_PHASES.

Verification (default parameters)
REQ-027 Release reset, hold phase_req=00100 -> ALLRED at cycle 0, phase 2 green from cycle 1, green held indefinitely.
REQ-028 Drop req[2] -> green 5 more cycles, yellow 2 cycles, red 1 cycle, then idle all-red; a req[2] pulse at gap count 3 clears the gap and extends green.
REQ-029 Hold phase_req=01001 -> phase 0 green 10, yellow 2, red 1, then phase 3 green 10, repeating alternately.
REQ-030 Pointer=3, phase_req=10010 -> phase 4 granted.
REQ-031 Phase 0 green at max count 3, preempt_req=1 with preempt_phase=1 -> yellow next cycle for 2 cycles, red 1, phase 1 green held while preempt_req=1.
REQ-032 Reset on the first yellow cycle -> all red next cycle, active_phase=4, subsequent req[0] granted first.
